// File: rtl/fetch_queue_stage.sv
// Instruction-fetch stage: sequential imem requests feeding a DEPTH-entry in-order queue to decode.
// Build macro FETCH_QUEUE_STATS_EN adds the fetched_cnt / dropped_cnt statistics outputs.
module fetch_queue_stage #(
    parameter int unsigned       DEPTH    = 4,
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    input  logic              PCSrcD,
    input  logic              JalD,
    input  logic [ADDR_W-1:0] PCTargetD,
    input  logic              StallD,
    output logic              ValidD,
    output logic [31:0]       InstrD,
    output logic [ADDR_W-1:0] PCD,
    output logic [ADDR_W-1:0] PCPlus4D
`ifdef FETCH_QUEUE_STATS_EN
    ,
    output logic [31:0]       fetched_cnt,
    output logic [31:0]       dropped_cnt
`endif
);

    localparam int unsigned       PTR_W     = $clog2(DEPTH);
    localparam int unsigned       CNT_W     = PTR_W + 1;
    localparam int unsigned       OCC_W     = CNT_W + 1;
    localparam logic [OCC_W-1:0]  DEPTH_OCC = OCC_W'(DEPTH);
    localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(4);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] req_pc_q,   req_pc_d;
    logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
    logic [CNT_W-1:0]  count_q,    count_d;
    logic              pending_q,  pending_d;
    logic              discard_q,  discard_d;
    logic [31:0]       instr_q [DEPTH];
    logic [ADDR_W-1:0] pc_q    [DEPTH];

    logic              redirect, resp, push, pop, issue;
    logic [OCC_W-1:0]  occ_after;

    assign ValidD = (count_q != '0);

    // occ_after counts the entries that will exist once this cycle's push/pop land;
    // a new request is only issued when its response is guaranteed a free slot.
    always_comb begin
        redirect  = PCSrcD | JalD;
        resp      = imem_rvalid & pending_q;
        push      = resp & ~discard_q & ~redirect;
        pop       = ValidD & ~StallD & ~redirect;
        occ_after = {1'b0, count_q} + OCC_W'(push) - OCC_W'(pop);
        issue     = ~rst & (~pending_q | imem_rvalid) & (occ_after < DEPTH_OCC) & ~redirect;
    end

    // NOTE: every _d gets a default first so no path through this block can infer a latch.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        pending_d  = pending_q;
        discard_d  = discard_q;
        if (redirect) begin
            fetch_pc_d = PCTargetD;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            pending_d  = pending_q & ~imem_rvalid;
            discard_d  = pending_q & ~imem_rvalid;
        end else begin
            if (resp) begin
                pending_d = 1'b0;
                discard_d = 1'b0;
            end
            if (issue) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
                req_pc_d   = fetch_pc_q;
                pending_d  = 1'b1;
                discard_d  = 1'b0;
            end
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = occ_after[CNT_W-1:0];
        end
    end

    // NOTE: the queue storage is reset too, so the head outputs read as zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            pending_q  <= 1'b0;
            discard_q  <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            pending_q  <= pending_d;
            discard_q  <= discard_d;
            if (push) begin
                instr_q[wr_ptr_q] <= imem_rdata;
                pc_q[wr_ptr_q]    <= req_pc_q;
            end
        end
    end

    assign imem_req  = issue;
    assign imem_addr = fetch_pc_q;
    assign InstrD    = instr_q[rd_ptr_q];
    assign PCD       = pc_q[rd_ptr_q];
    assign PCPlus4D  = pc_q[rd_ptr_q] + PC_STEP;

`ifdef FETCH_QUEUE_STATS_EN
    logic [31:0] fetched_q, dropped_q, drop_inc;

    // A redirect drops every queued entry plus any response landing in the same cycle.
    always_comb begin
        drop_inc = redirect ? (32'(count_q) + 32'(resp)) : 32'(resp & discard_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetched_q <= '0;
            dropped_q <= '0;
        end else begin
            fetched_q <= fetched_q + 32'(push);
            dropped_q <= dropped_q + drop_inc;
        end
    end

    assign fetched_cnt = fetched_q;
    assign dropped_cnt = dropped_q;
`endif

endmodule
